// File: rtl/dncnt_reload.sv
// rtl/dncnt_reload.sv - loadable cascadable down-counter with auto-reload and terminal-count pulse
module dncnt_reload #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resl,
  input  logic             ci,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  input  logic             rld,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             tc
);

  logic [WIDTH-1:0] per;
  logic             q_zero;

  assign q_zero = (q == '0);

  // Borrow is left ungated by ld so an upper slice in a cascade always sees a consistent borrow.
  assign co = ci & q_zero;

  always_ff @(posedge clk or negedge resl) begin
    if (!resl) begin
      q   <= '0;
      per <= '0;
      tc  <= 1'b0;
    end else if (ld) begin
      q   <= d;
      per <= d;
      tc  <= 1'b0;
    end else if (ci) begin
      if (q_zero) begin
        q  <= rld ? per : '1;
        tc <= 1'b1;
      end else begin
        q  <= q - WIDTH'(1);
        tc <= 1'b0;
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dncnt_reload.sv
// tb/tb_dncnt_reload.sv - directed self-checking bench for dncnt_reload
module tb_dncnt_reload;

  logic        clk = 1'b0;
  logic        resl;
  logic        ci, ld, rld;
  logic [15:0] d;
  logic [15:0] q;
  logic        co, tc;

  logic        c_ci, c_ld, c_rld;
  logic [7:0]  lo_d, hi_d, lo_q, hi_q;
  logic        lo_co, hi_co, lo_tc, hi_tc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dncnt_reload #(.WIDTH(16)) dut (
    .clk(clk), .resl(resl), .ci(ci), .ld(ld), .d(d), .rld(rld),
    .q(q), .co(co), .tc(tc)
  );

  dncnt_reload #(.WIDTH(8)) lo (
    .clk(clk), .resl(resl), .ci(c_ci), .ld(c_ld), .d(lo_d), .rld(c_rld),
    .q(lo_q), .co(lo_co), .tc(lo_tc)
  );

  dncnt_reload #(.WIDTH(8)) hi (
    .clk(clk), .resl(resl), .ci(lo_co), .ld(c_ld), .d(hi_d), .rld(c_rld),
    .q(hi_q), .co(hi_co), .tc(hi_tc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int tc_count;
    int tc_last;
    int spacing_bad;
    int q_bad;

    resl = 1'b0; ci = 1'b0; ld = 1'b0; rld = 1'b1; d = '0;
    c_ci = 1'b0; c_ld = 1'b0; c_rld = 1'b0; lo_d = '0; hi_d = '0;

    step(); step();
    check("reset_q", q, 16'h0000);
    check("reset_tc", tc, 1'b0);
    check("reset_co_ci0", co, 1'b0);
    ci = 1'b1; #1;
    check("reset_co_ci1", co, 1'b1);
    ci = 1'b0;
    resl = 1'b1;

    // load 0x1234, then assert reset mid-cycle while counting
    ld = 1'b1; d = 16'h1234; step();
    ld = 1'b0;
    check("load_1234", q, 16'h1234);
    ci = 1'b1; #3;
    resl = 1'b0; #1;
    check("async_reset_q", q, 16'h0000);
    check("async_reset_tc", tc, 1'b0);
    ci = 1'b0;
    step();
    resl = 1'b1;
    step();
    check("post_reset_hold", q, 16'h0000);

    // load 3 and count through underflow with reload
    ld = 1'b1; d = 16'h0003; ci = 1'b1; rld = 1'b1; step();
    check("ld3_q", q, 16'h0003);
    check("ld3_tc", tc, 1'b0);
    ld = 1'b0;
    step();
    check("cnt_q2", q, 16'h0002);
    check("cnt_co_q2", co, 1'b0);
    step();
    check("cnt_q1", q, 16'h0001);
    check("cnt_tc_q1", tc, 1'b0);
    step();
    check("cnt_q0", q, 16'h0000);
    check("cnt_tc_q0", tc, 1'b0);
    check("cnt_co_q0", co, 1'b1);
    step();
    check("reload_q", q, 16'h0003);
    check("reload_tc", tc, 1'b1);
    check("reload_co", co, 1'b0);
    step();
    check("after_reload_q", q, 16'h0002);
    check("after_reload_tc", tc, 1'b0);

    // free wrap
    step(); step();
    check("wrap_pre_q", q, 16'h0000);
    rld = 1'b0;
    step();
    check("wrap_q", q, 16'hFFFF);
    check("wrap_tc", tc, 1'b1);
    step();
    check("wrap_next_q", q, 16'hFFFE);
    check("wrap_next_tc", tc, 1'b0);

    // ld beats ci while q == 0
    ld = 1'b1; d = 16'h0000; ci = 1'b0; step();
    check("prio_pre_q", q, 16'h0000);
    d = 16'h00AA; ci = 1'b1; #1;
    check("prio_co", co, 1'b1);
    step();
    check("prio_q", q, 16'h00AA);
    check("prio_tc", tc, 1'b0);
    ld = 1'b0; ci = 1'b0;

    // divider with period 4
    ld = 1'b1; d = 16'h0004; rld = 1'b1; step();
    ld = 1'b0; ci = 1'b1;
    tc_count = 0; tc_last = 0; spacing_bad = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (tc === 1'b1) begin
        if (i - tc_last != 5) spacing_bad++;
        tc_last = i;
        tc_count++;
      end
    end
    check("div4_pulses", tc_count, 4);
    check("div4_spacing", spacing_bad, 0);

    // period 0: tc every cycle, q stuck at 0
    ci = 1'b0; ld = 1'b1; d = 16'h0000; step();
    ld = 1'b0; ci = 1'b1;
    tc_count = 0; q_bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tc === 1'b1) tc_count++;
      if (q !== 16'h0000) q_bad++;
    end
    check("div0_pulses", tc_count, 10);
    check("div0_q", q_bad, 0);
    ci = 1'b0;

    // cascade of two 8-bit slices
    c_ld = 1'b1; lo_d = 8'h01; hi_d = 8'h00; c_rld = 1'b0; step();
    c_ld = 1'b0;
    check("casc_load", {hi_q, lo_q}, 16'h0001);
    c_ci = 1'b1; #1;
    check("casc_lo_co0", lo_co, 1'b0);
    step();
    check("casc_zero", {hi_q, lo_q}, 16'h0000);
    check("casc_lo_co1", lo_co, 1'b1);
    check("casc_hi_co1", hi_co, 1'b1);
    step();
    check("casc_wrap", {hi_q, lo_q}, 16'hFFFF);
    check("casc_lo_tc", lo_tc, 1'b1);
    check("casc_hi_tc", hi_tc, 1'b1);
    step();
    check("casc_next", {hi_q, lo_q}, 16'hFFFE);
    check("casc_lo_tc_off", lo_tc, 1'b0);
    check("casc_hi_tc_off", hi_tc, 1'b0);
    c_ci = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
